// File: rtl/rsr_iterative.sv
// -----------------------------------------------------------------------------
// rsr_iterative
//
// Multi-cycle rotate-right unit for the ALU shifter. An operand and a rotate
// amount are accepted through a valid/ready handshake. The operand is then
// rotated right by one bit per clock until the amount is exhausted. The
// result, together with the last bit rotated out of bit 0 (the carry flag
// source), is held until the downstream stage takes it.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   in_valid     operand/shift presented
//   in_ready     unit can accept a new operand (IDLE only)
//   inp          WIDTH-bit operand
//   shift_value  rotate-right amount N, 0..WIDTH-1
//   out_valid    result available (DONE)
//   out_ready    downstream takes the result
//   out          registered rotated result
//   carry        registered last bit rotated out of bit 0
//   busy         unit is not IDLE
// -----------------------------------------------------------------------------
module rsr_iterative #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp,
    input  logic [SHW-1:0]   shift_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   cnt;
    logic             lb;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] data_rot;

    assign accept    = (state == IDLE) && in_valid;
    // The final rotate happens on the edge where the counter still reads one.
    assign last_step = (state == ROTATE) && (cnt == SHW'(1));
    assign data_rot  = {data[0], data[WIDTH-1:1]};

    // Handshake and status flags are pure decodes of the state register.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every register in this file is written with non-blocking
    // assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next is given its hold value before the case so that no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (shift_value != '0) ? ROTATE : DONE;
                end
            end
            ROTATE: begin
                if (cnt == SHW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Consuming edge only returns to IDLE; a new operand waits
                // for the following edge, so results and accepts never overlap.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: work register, counter and last-out bit
    // -------------------------------------------------------------------------
    // NOTE: these are ordinary flops (not a memory array), so they are all
    // cleared by reset; an aborted operation leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            cnt  <= '0;
            lb   <= 1'b0;
        end else if (accept) begin
            data <= inp;
            cnt  <= shift_value;
            lb   <= 1'b0;
        end else if (state == ROTATE) begin
            data <= data_rot;
            lb   <= data[0];
            cnt  <= cnt - SHW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Result registers: loaded only on entry to DONE, held otherwise
    // -------------------------------------------------------------------------
    // On entry the work register has not yet absorbed the final rotate, so
    // the result is taken from the combinational next value. A zero amount
    // enters DONE straight from IDLE and passes the operand through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out   <= '0;
            carry <= 1'b0;
        end else if (accept && (shift_value == '0)) begin
            out   <= inp;
            carry <= 1'b0;
        end else if (last_step) begin
            out   <= data_rot;
            carry <= data[0];
        end
    end

endmodule

// File: tb/tb_rsr_iterative.sv
// -----------------------------------------------------------------------------
// tb_rsr_iterative
//
// Directed self-checking bench for rsr_iterative (WIDTH=16). Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_rsr_iterative;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;
    localparam int LAT_LIMIT = 40;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inp;
    logic [SHW-1:0]   shift_value;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             busy;

    int total = 0;
    int bad   = 0;

    rsr_iterative #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inp         (inp),
        .shift_value (shift_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .carry       (carry),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand for exactly the accept edge E0; returns at E0+1.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [SHW-1:0] n);
        in_valid    = 1'b1;
        inp         = a;
        shift_value = n;
        tick();
        in_valid    = 1'b0;
    endtask

    // Counts further edges until out_valid, bounded by LAT_LIMIT.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < LAT_LIMIT) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_initial();
        #2 rst = 1'b0;
        #1;
        total++;
        if ({out, carry, out_valid, in_ready, busy} !== {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_initial: out=%h carry=%b ov=%b ir=%b busy=%b, need 0000 0 0 1 0",
                     out, carry, out_valid, in_ready, busy);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'h000B, 4'd4);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_after_accept: busy=%b ir=%b ov=%b, need 1 0 0", busy, in_ready, out_valid);
        end
        wait_done(lat);
        total++;
        if (lat !== 4 || out !== 16'hB000 || carry !== 1'b1) begin
            bad++;
            $display("FAIL basic_result: lat=%0d out=%h carry=%b, need 4 b000 1", lat, out, carry);
        end
        consume();
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out !== 16'hB000 || carry !== 1'b1) begin
            bad++;
            $display("FAIL basic_consume: ir=%b busy=%b ov=%b out=%h carry=%b, need 1 0 0 b000 1",
                     in_ready, busy, out_valid, out, carry);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        start_op(16'h000B, 4'd4);
        tick();
        rst = 1'b0;
        #1;
        total++;
        if ({out, carry, out_valid, in_ready, busy} !== {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_op: out=%h carry=%b ov=%b ir=%b busy=%b, need 0000 0 0 1 0",
                     out, carry, out_valid, in_ready, busy);
        end
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_release_quiet: active_cycles=%0d, need 0", seen);
        end
    endtask

    task automatic test_single_step();
        int lat;
        start_op(16'h8001, 4'd1);
        wait_done(lat);
        total++;
        if (lat !== 1 || out !== 16'hC000 || carry !== 1'b1) begin
            bad++;
            $display("FAIL single_step: lat=%0d out=%h carry=%b, need 1 c000 1", lat, out, carry);
        end
        consume();
    endtask

    task automatic test_zero_shift();
        int lat;
        start_op(16'h1234, 4'd0);
        wait_done(lat);
        total++;
        if (lat !== 0 || out !== 16'h1234 || carry !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_shift: lat=%0d out=%h carry=%b busy=%b, need 0 1234 0 1",
                     lat, out, carry, busy);
        end
        consume();
    endtask

    task automatic test_max_shift();
        int lat;
        start_op(16'h0001, 4'd15);
        wait_done(lat);
        total++;
        if (lat !== 15 || out !== 16'h0002 || carry !== 1'b0) begin
            bad++;
            $display("FAIL max_shift_a: lat=%0d out=%h carry=%b, need 15 0002 0", lat, out, carry);
        end
        consume();
        start_op(16'hFFFF, 4'd15);
        repeat (5) tick();
        // Result registers must still hold the previous answer mid-rotate.
        total++;
        if (out !== 16'h0002 || carry !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL max_shift_hold: out=%h carry=%b ov=%b busy=%b, need 0002 0 0 1",
                     out, carry, out_valid, busy);
        end
        wait_done(lat);
        total++;
        if (lat !== 10 || out !== 16'hFFFF || carry !== 1'b1) begin
            bad++;
            $display("FAIL max_shift_b: lat=%0d out=%h carry=%b, need 10 ffff 1", lat, out, carry);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int unstable;
        start_op(16'h00F0, 4'd3);
        wait_done(lat);
        total++;
        if (lat !== 3 || out !== 16'h001E || carry !== 1'b0) begin
            bad++;
            $display("FAIL bp_result: lat=%0d out=%h carry=%b, need 3 001e 0", lat, out, carry);
        end
        in_valid    = 1'b1;
        inp         = 16'h5555;
        shift_value = 4'd1;
        unstable    = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out !== 16'h001E || carry !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) unstable++;
        end
        total++;
        if (unstable !== 0) begin
            bad++;
            $display("FAIL bp_hold: unstable_cycles=%0d, need 0", unstable);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: ir=%b busy=%b ov=%b, need 1 0 0", in_ready, busy, out_valid);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept: busy=%b ov=%b, need 1 0", busy, out_valid);
        end
        wait_done(lat);
        total++;
        if (lat !== 1 || out !== 16'hAAAA || carry !== 1'b1) begin
            bad++;
            $display("FAIL bp_second: lat=%0d out=%h carry=%b, need 1 aaaa 1", lat, out, carry);
        end
        consume();
    endtask

    // With out_ready and in_valid held high, N=2 ops issue every 4 edges.
    task automatic test_back_to_back();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        inp         = 16'h0003;
        shift_value = 4'd2;
        tick();                 // E0 accept
        inp = 16'h0004;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept0: busy=%b, need 1", busy);
        end
        tick();                 // E1
        tick();                 // E2 -> DONE
        total++;
        if (out_valid !== 1'b1 || out !== 16'hC000 || carry !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: ov=%b out=%h carry=%b, need 1 c000 1", out_valid, out, carry);
        end
        tick();                 // E3 consume
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: ir=%b busy=%b, need 1 0", in_ready, busy);
        end
        tick();                 // E4 accept second
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || out !== 16'hC000) begin
            bad++;
            $display("FAIL b2b_accept1: busy=%b out=%h, need 1 c000", busy, out);
        end
        tick();                 // E5
        tick();                 // E6 -> DONE
        total++;
        if (out_valid !== 1'b1 || out !== 16'h0001 || carry !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: ov=%b out=%h carry=%b, need 1 0001 0", out_valid, out, carry);
        end
        tick();                 // E7 consume
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: ir=%b ov=%b, need 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        inp         = '0;
        shift_value = '0;
        out_ready   = 1'b0;

        test_reset_initial();
        test_basic();
        test_reset_mid_op();
        test_single_step();
        test_zero_shift();
        test_max_shift();
        test_backpressure();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
